dm_arbiter: RTL

Two-requester arbiter and sequencer for the single-port byte-addressed data memory (big-endian 32-bit words, synchronous write, combinational read). It shares the memory between the CPU load/store path and a debug/dump port used by the test environment. Each transaction is latched, driven onto the memory for exactly one cycle and then completed with a registered response. Sits between the CPU datapath / debug master and the data-memory instance.

---
 rtl/dm_arb_pkg.sv | 18 +
 rtl/dm_arbiter_if.sv | 55 +++++
 rtl/rr_arb2.sv | 27 ++
 rtl/dm_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   state_t           : sequencer state (IDLE, BUSY)
//   REQ_CPU / REQ_DBG : requester ids; bit index in the request vector
//   DEF_ADDR_W / DEF_DATA_W : default bus widths
package dm_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two requesters (CPU, debug), the arbiter and the
// data memory.
//   cpu_* / dbg_* : request (req, we, addr, wdata) and response (gnt, done,
//                   rdata, err) per requester
//   address, dm_in, MemWrite, MemRead : arbiter -> memory
//   dm_out        : memory -> arbiter (combinational read data)
// Modports: slave = arbiter, master = requesters plus memory side.
interface dm_arbiter_if #(
  parameter int unsigned ADDR_W = dm_arb_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = dm_arb_pkg::DEF_DATA_W
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_err;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_done;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_err;

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] dm_in;
  logic [DATA_W-1:0] dm_out;
  logic              MemWrite;
  logic              MemRead;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_done, cpu_rdata, cpu_err,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_done, dbg_rdata, dbg_err,
    output address, dm_in, MemWrite, MemRead,
    input  dm_out
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_done, cpu_rdata, cpu_err,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_done, dbg_rdata, dbg_err,
    input  address, dm_in, MemWrite, MemRead,
    output dm_out
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker, purely combinational.
//   i_req[1:0]  : request vector, bit REQ_CPU / REQ_DBG
//   i_last      : id of the requester granted last
//   o_gnt_id_c  : id of the winner (meaningful when o_valid_c = 1)
//   o_valid_c   : at least one request present
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_gnt_id_c,
  output logic       o_valid_c
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    o_valid_c  = |i_req;
    o_gnt_id_c = REQ_CPU;
    case (i_req)
      2'b01:   o_gnt_id_c = REQ_CPU;
      2'b10:   o_gnt_id_c = REQ_DBG;
      2'b11:   o_gnt_id_c = ~i_last;
      default: o_gnt_id_c = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter / sequencer for the single-port data memory.
// Each accepted request is latched, driven onto the memory for one BUSY
// cycle, and completed with a registered done/rdata/err pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dm_arbiter_if.slave (both requester ports + memory port)
// Optional feature: DM_ARB_ALIGN_CHECK_EN -- word accesses with addr[1:0] != 0
// are suppressed at the memory and completed with err = 1, rdata = 0.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic        clk,
  input  logic        rst_n,
  dm_arbiter_if.slave bus
);

  state_t            r_state;
  state_t            w_state_nxt;

  // Latched transaction and arbitration history
  logic              r_last;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  // Registered outputs
  logic              r_cpu_gnt;
  logic              r_dbg_gnt;
  logic              r_cpu_done;
  logic              r_dbg_done;
  logic              r_cpu_err;
  logic              r_dbg_err;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic              r_mem_we;
  logic              r_mem_re;

  // Next values of all registers
  logic              w_last_d;
  logic              w_owner_d;
  logic              w_we_d;
  logic [ADDR_W-1:0] w_addr_d;
  logic [DATA_W-1:0] w_wdata_d;
  logic              w_cpu_gnt_d;
  logic              w_dbg_gnt_d;
  logic              w_cpu_done_d;
  logic              w_dbg_done_d;
  logic              w_cpu_err_d;
  logic              w_dbg_err_d;
  logic [DATA_W-1:0] w_cpu_rdata_d;
  logic [DATA_W-1:0] w_dbg_rdata_d;
  logic              w_mem_we_d;
  logic              w_mem_re_d;

  logic              w_arb_id;
  logic              w_arb_valid;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_misalign;
  logic              w_busy_misalign;
  logic [DATA_W-1:0] w_load_data;

  rr_arb2 u_rr_arb2 (
    .i_req      ({bus.dbg_req, bus.cpu_req}),
    .i_last     (r_last),
    .o_gnt_id_c (w_arb_id),
    .o_valid_c  (w_arb_valid)
  );

  // Fields of the requester the picker selected
  assign w_sel_we    = (w_arb_id == REQ_DBG) ? bus.dbg_we    : bus.cpu_we;
  assign w_sel_addr  = (w_arb_id == REQ_DBG) ? bus.dbg_addr  : bus.cpu_addr;
  assign w_sel_wdata = (w_arb_id == REQ_DBG) ? bus.dbg_wdata : bus.cpu_wdata;

`ifdef DM_ARB_ALIGN_CHECK_EN
  assign w_sel_misalign  = |w_sel_addr[1:0];
  assign w_busy_misalign = |r_addr[1:0];
`else
  assign w_sel_misalign  = 1'b0;
  assign w_busy_misalign = 1'b0;
`endif

  // A rejected access returns zero instead of whatever the memory shows
  assign w_load_data = w_busy_misalign ? '0 : bus.dm_out;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: every access is exactly one BUSY cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_arb_valid) w_state_nxt = BUSY;
      BUSY:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_last_d      = r_last;
    w_owner_d     = r_owner;
    w_we_d        = r_we;
    w_addr_d      = r_addr;
    w_wdata_d     = r_wdata;
    w_cpu_gnt_d   = 1'b0;
    w_dbg_gnt_d   = 1'b0;
    w_cpu_done_d  = 1'b0;
    w_dbg_done_d  = 1'b0;
    w_cpu_err_d   = 1'b0;
    w_dbg_err_d   = 1'b0;
    w_cpu_rdata_d = r_cpu_rdata;
    w_dbg_rdata_d = r_dbg_rdata;
    w_mem_we_d    = 1'b0;
    w_mem_re_d    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_last_d    = w_arb_id;
          w_owner_d   = w_arb_id;
          w_we_d      = w_sel_we;
          w_addr_d    = w_sel_addr;
          w_wdata_d   = w_sel_wdata;
          w_cpu_gnt_d = (w_arb_id == REQ_CPU);
          w_dbg_gnt_d = (w_arb_id == REQ_DBG);
          // Strobes are registered so they are live during the BUSY cycle
          w_mem_we_d  = w_sel_we & ~w_sel_misalign;
          w_mem_re_d  = ~w_sel_we & ~w_sel_misalign;
        end
      end
      BUSY: begin
        if (r_owner == REQ_DBG) begin
          w_dbg_done_d = 1'b1;
          w_dbg_err_d  = w_busy_misalign;
          if (!r_we || w_busy_misalign) w_dbg_rdata_d = w_load_data;
        end else begin
          w_cpu_done_d = 1'b1;
          w_cpu_err_d  = w_busy_misalign;
          if (!r_we || w_busy_misalign) w_cpu_rdata_d = w_load_data;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; last-winner resets to DBG so CPU wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= REQ_DBG;
      r_owner     <= REQ_CPU;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_gnt   <= 1'b0;
      r_dbg_gnt   <= 1'b0;
      r_cpu_done  <= 1'b0;
      r_dbg_done  <= 1'b0;
      r_cpu_err   <= 1'b0;
      r_dbg_err   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
    end else begin
      r_last      <= w_last_d;
      r_owner     <= w_owner_d;
      r_we        <= w_we_d;
      r_addr      <= w_addr_d;
      r_wdata     <= w_wdata_d;
      r_cpu_gnt   <= w_cpu_gnt_d;
      r_dbg_gnt   <= w_dbg_gnt_d;
      r_cpu_done  <= w_cpu_done_d;
      r_dbg_done  <= w_dbg_done_d;
      r_cpu_err   <= w_cpu_err_d;
      r_dbg_err   <= w_dbg_err_d;
      r_cpu_rdata <= w_cpu_rdata_d;
      r_dbg_rdata <= w_dbg_rdata_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_re    <= w_mem_re_d;
    end
  end

  assign bus.cpu_gnt   = r_cpu_gnt;
  assign bus.cpu_done  = r_cpu_done;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_err   = r_cpu_err;
  assign bus.dbg_gnt   = r_dbg_gnt;
  assign bus.dbg_done  = r_dbg_done;
  assign bus.dbg_rdata = r_dbg_rdata;
  assign bus.dbg_err   = r_dbg_err;
  assign bus.address   = r_addr;
  assign bus.dm_in     = r_wdata;
  assign bus.MemWrite  = r_mem_we;
  assign bus.MemRead   = r_mem_re;

endmodule
